rll27_serial_encoder: RTL
=========================

RLL27_SERIAL_ENCODER -- requirements
Module: rll27_serial_encoder

Interface
REQ-001 SHALL have parameter DATA_W, default 8, input word width in bits, legal range 4..32.
REQ-002 SHALL have parameter BUF_W, default 2*DATA_W, pending-data buffer depth in bits, BUF_W >= DATA_W+3.
REQ-003 SHALL have port clk_i input 1: the single clock; all logic on rising edge.
REQ-004 SHALL have port rst_i input 1: reset, synchronous and active-high.
REQ-005 SHALL have port data_i input DATA_W: user data word, MSB transmitted first.
REQ-006 SHALL have port data_valid_i input 1: data_i is valid.
REQ-007 SHALL have port data_ready_o output 1: the encoder can accept a word this cycle.
REQ-008 SHALL have port flush_i input 1: one-cycle pulse that zero-pads the residual bits and terminates the stream.
REQ-009 SHALL have port nrzi_en_i input 1: 1 = line_o is NRZI, 0 = line_o equals code_o.
REQ-010 SHALL have port code_o output 1: current (2,7) channel bit, NRZ.
REQ-011 SHALL have port code_valid_o output 1: code_o and line_o carry a channel bit this cycle.
REQ-012 SHALL have port line_o output 1: line level driven to the medium.
REQ-013 SHALL have port busy_o output 1: the buffer or the output shifter holds pending bits.

Function
REQ-014 SHALL accept a word on any rising edge with data_valid_i=1 and data_ready_o=1, appending its DATA_W bits MSB-first to the pending buffer.
REQ-015 SHALL drive data_ready_o=1 only when free buffer space >= DATA_W; it is registered and independent of data_valid_i.
REQ-016 SHALL parse pending bits MSB-first with the (2,7) prefix table: 10->0100, 11->1000, 000->000100, 010->100100, 011->001000, 0010->00100100, 0011->00001000.
REQ-017 SHALL not consume a prefix until enough bits are buffered to match it; a partial prefix waits for the next word.
REQ-018 SHALL load the matched codeword (4, 6 or 8 bits) into an 8-bit output shifter when the shifter is empty or presents its last bit, with no gap between back-to-back codewords.
REQ-019 SHALL emit one code bit per clock, MSB of the codeword first, with code_valid_o=1 while bits are shifted.
REQ-020 SHALL hold code_valid_o=0 and code_o=0 when no codeword is available (underrun); line_o holds its level.
REQ-021 SHALL, with nrzi_en_i=1, toggle line_o in the same cycle code_o=1 is valid, else hold; with nrzi_en_i=0, line_o=code_o when valid, else 0.
REQ-022 SHALL sample nrzi_en_i every cycle; a change affects the next emitted bit only.
REQ-023 SHALL, on flush_i, append zeros to the residual until a table entry matches (0->000, 1->10, 00->000, 01->010, 001->0010), then encode it; with no residual, flush_i has no effect.
REQ-024 SHALL, when flush_i and an accepted word coincide, append the word first and apply the flush after it.
REQ-025 SHALL, when idle with an empty buffer, present the first code bit on code_o exactly 2 cycles after the acceptance edge.
REQ-026 SHALL keep busy_o=1 from the acceptance edge until the last code bit has been emitted.
REQ-027 SHALL, after flush and drain, produce a channel stream whose concatenation obeys d=2, k=7: 2 to 7 zeros between consecutive ones.

Reset
REQ-028 SHALL, on rst_i=1 at a rising edge, clear the buffer and the shifter and drop any pending flush, setting code_o=0, code_valid_o=0, line_o=0, busy_o=0, data_ready_o=1 on the next cycle.
REQ-029 SHALL give reset priority over acceptance and flush; a word presented during reset is not accepted, and reset mid-codeword discards the remaining bits.

Verification (DATA_W=8)
REQ-030 SHALL cover: word 8'b1011_0010, nrzi_en_i=0 -> code_o = 0100 1000 00100100 (16 valid bits), first bit 2 cycles after acceptance.
REQ-031 SHALL cover: word 8'b0000_0011 -> 000100 000100 1000 back-to-back, no code_valid_o gap.
REQ-032 SHALL cover: word 8'b0100_0000 then flush_i -> 100100 000100 000100, then busy_o=0.
REQ-033 SHALL cover: nrzi_en_i=1, word 8'b1010_1010 -> code 0100 repeated 4 times; line_o toggles once per codeword, ending at 0.
REQ-034 SHALL cover: rst_i asserted mid-codeword -> next cycle code_valid_o=0, line_o=0, data_ready_o=1, and no residual bits appear later.
REQ-035 SHALL cover: 1000 random words with random valid gaps plus a final flush -> a reference-model match, d=2/k=7 holds, and no word is accepted while data_ready_o=0.

Source files
------------

// File: rtl/rll27_serial_encoder.sv
// rll27_serial_encoder
// Serial (2,7) run-length-limited channel encoder. User words are appended
// MSB-first to a pending bit buffer, parsed with the (2,7) prefix table and
// streamed out one channel bit per clock, optionally NRZI-modulated.
//
// Ports:
//   clk_i         single clock, all logic on the rising edge
//   rst_i         synchronous active-high reset
//   data_i        user data word, MSB transmitted first
//   data_valid_i  data_i is valid
//   data_ready_o  a word can be accepted this cycle (registered)
//   flush_i       pulse: zero-pad the residual bits and terminate the stream
//   nrzi_en_i     1 = line_o is NRZI, 0 = line_o follows code_o
//   code_o        current NRZ channel bit
//   code_valid_o  code_o / line_o carry a channel bit this cycle
//   line_o        line level driven to the medium
//   busy_o        buffer, shifter or output stage holds pending bits
module rll27_serial_encoder #(
    parameter int DATA_W = 8,
    parameter int BUF_W  = 2 * DATA_W
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [DATA_W-1:0] data_i,
    input  logic              data_valid_i,
    output logic              data_ready_o,
    input  logic              flush_i,
    input  logic              nrzi_en_i,
    output logic              code_o,
    output logic              code_valid_o,
    output logic              line_o,
    output logic              busy_o
);

    localparam int               CNT_W     = $clog2(BUF_W + 1);
    localparam logic [CNT_W-1:0] MAX_FILL  = CNT_W'(BUF_W - DATA_W);
    localparam logic [CNT_W-1:0] WORD_BITS = CNT_W'(DATA_W);

    // Pending bits are left-aligned: pend_q[BUF_W-1] is the oldest bit and
    // every position at or below the fill level is kept at zero. That zero
    // tail doubles as the flush padding, so a flushed residual is parsed by
    // simply ignoring the "enough bits buffered" condition.
    logic [BUF_W-1:0] pend_q;
    logic [BUF_W-1:0] pend_shift;
    logic [BUF_W-1:0] pend_d;
    logic [BUF_W-1:0] word_ext;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_rem;
    logic [CNT_W-1:0] cnt_d;
    logic             flush_q;
    logic             flush_d;

    logic [7:0]       sh_q;
    logic [7:0]       sh_d;
    logic [3:0]       sh_cnt_q;
    logic [3:0]       sh_cnt_d;

    logic [3:0]       head;
    logic [2:0]       pat_len;
    logic [CNT_W-1:0] pat_len_w;
    logic [CNT_W-1:0] take;
    logic [7:0]       cw;
    logic [3:0]       cw_len;
    logic             match;
    logic             load;
    logic             accept;
    logic             emit;
    logic             bit_out;

    // Prefix parser: look at the four oldest buffered bits and pick the
    // matching table entry. Codewords are returned left-aligned in 8 bits.
    always_comb begin
        head    = pend_q[BUF_W-1 -: 4];
        pat_len = 3'd2;
        cw      = 8'b0100_0000;
        cw_len  = 4'd4;
        if (head[3]) begin
            pat_len = 3'd2;
            cw_len  = 4'd4;
            cw      = head[2] ? 8'b1000_0000 : 8'b0100_0000;
        end else begin
            case (head[2:1])
                2'b00: begin
                    pat_len = 3'd3;
                    cw_len  = 4'd6;
                    cw      = 8'b0001_0000;
                end
                2'b10: begin
                    pat_len = 3'd3;
                    cw_len  = 4'd6;
                    cw      = 8'b1001_0000;
                end
                2'b11: begin
                    pat_len = 3'd3;
                    cw_len  = 4'd6;
                    cw      = 8'b0010_0000;
                end
                default: begin
                    pat_len = 3'd4;
                    cw_len  = 4'd8;
                    cw      = head[0] ? 8'b0000_1000 : 8'b0010_0100;
                end
            endcase
        end
    end

    // Next-state logic. The shifter reloads when empty or while its last bit
    // moves to the output stage, which keeps codewords back-to-back. The
    // buffer first loses the consumed prefix and then gains the new word,
    // so a word and a flush in the same cycle pad after that word.
    always_comb begin
        pat_len_w = CNT_W'(pat_len);
        match     = (cnt_q != '0) && ((pat_len_w <= cnt_q) || flush_q);
        load      = match && (sh_cnt_q <= 4'd1);
        take      = '0;
        if (load) begin
            take = (pat_len_w <= cnt_q) ? pat_len_w : cnt_q;
        end

        accept     = data_valid_i && data_ready_o;
        pend_shift = pend_q << take;
        cnt_rem    = cnt_q - take;
        word_ext   = {data_i, {(BUF_W - DATA_W){1'b0}}};
        pend_d     = pend_shift;
        cnt_d      = cnt_rem;
        if (accept) begin
            pend_d = pend_shift | (word_ext >> cnt_rem);
            cnt_d  = cnt_rem + WORD_BITS;
        end

        // A flush only means something while there are bits to terminate;
        // it stays armed until the padded residual has been consumed.
        flush_d = (flush_q || flush_i) && (cnt_d != '0);

        emit    = (sh_cnt_q != 4'd0);
        bit_out = emit && sh_q[7];
        sh_d     = sh_q;
        sh_cnt_d = sh_cnt_q;
        if (load) begin
            sh_d     = cw;
            sh_cnt_d = cw_len;
        end else if (emit) begin
            sh_d     = sh_q << 1;
            sh_cnt_d = sh_cnt_q - 4'd1;
        end
    end

    // State and registered outputs. Acceptance is held off while a flush is
    // armed so the residual being padded cannot be extended by a later word.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pend_q       <= '0;
            cnt_q        <= '0;
            flush_q      <= 1'b0;
            sh_q         <= 8'd0;
            sh_cnt_q     <= 4'd0;
            code_o       <= 1'b0;
            code_valid_o <= 1'b0;
            line_o       <= 1'b0;
            busy_o       <= 1'b0;
            data_ready_o <= 1'b1;
        end else begin
            pend_q       <= pend_d;
            cnt_q        <= cnt_d;
            flush_q      <= flush_d;
            sh_q         <= sh_d;
            sh_cnt_q     <= sh_cnt_d;
            code_o       <= bit_out;
            code_valid_o <= emit;
            line_o       <= nrzi_en_i ? (line_o ^ bit_out) : bit_out;
            busy_o       <= (cnt_d != '0) || (sh_cnt_d != 4'd0) || emit;
            data_ready_o <= (cnt_d <= MAX_FILL) && !flush_d;
        end
    end

endmodule
